// File: rtl/parallax_pkg.sv
// Shared types, widths and helpers for the parallax skyline generator.
package parallax_pkg;

  // Building-height LFSR: Fibonacci form, feedback = s[TAP_HI] ^ s[TAP_LO], shifted in at bit 0.
  localparam int LFSR_W = 9;
  localparam int TAP_HI = LFSR_W - 1;
  localparam int TAP_LO = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED = '1;

  // Per-layer configuration field widths (also the packing stride on the top-level buses).
  localparam int COL_W   = 2;  // column width exponent
  localparam int RATE_W  = 3;  // frames per origin step minus one
  localparam int VPOS_W  = 10; // line number / horizon
  localparam int STEP_W  = 3;  // lines per cutoff increment exponent
  localparam int COLOR_W = 9;  // {r3,g3,b3}
  localparam int COUNT_W = 3;  // column pixel counter, holds up to 2^3-1

  typedef struct packed {
    logic [COL_W-1:0]   col_log2;
    logic [RATE_W-1:0]  rate;
    logic [VPOS_W-1:0]  horizon;
    logic [STEP_W-1:0]  step_log2;
    logic               border_en;
    logic [COLOR_W-1:0] fill_color;
    logic [COLOR_W-1:0] edge_color;
  } layer_cfg_t;

  // Low bit of layer 'layer' inside a packed bus with 'width' bits per layer.
  function automatic int field_lo(input int layer, input int width);
    return layer * width;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

  // Mask selecting the valid counter bits for a column of 2^n pixels.
  function automatic logic [COUNT_W-1:0] col_mask(input logic [COL_W-1:0] n);
    return COUNT_W'((1 << n) - 1);
  endfunction

endpackage

// File: rtl/parallax_scroller_engine_layer.sv
// One skyline layer: frame-shadowed config, scroll divider, origin and working
// height LFSRs with column counters, per-line cutoff and vertical-border flag.
module parallax_layer
  import parallax_pkg::*;
#(
  parameter int HEIGHT_W = 4,
  parameter int CUTOFF_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_start_i,
  input  logic               frame_start_i,
  input  logic               visible_i,
  input  logic               scroll_en_i,
  input  logic [VPOS_W-1:0]  vcount_i,
  input  layer_cfg_t         cfg_i,
  output logic               solid_o,
  output logic               border_o,
  output logic [COLOR_W-1:0] fill_o,
  output logic [COLOR_W-1:0] edge_o
);

  localparam logic [VPOS_W-1:0] CUT_MAX = VPOS_W'((1 << CUTOFF_W) - 1);

  layer_cfg_t          cfg_q;
  logic [RATE_W-1:0]   div_q, div_d;
  logic [LFSR_W-1:0]   olfsr_q, olfsr_d;
  logic [COUNT_W-1:0]  ocount_q, ocount_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [COUNT_W-1:0]  count_q;
  logic [CUTOFF_W-1:0] cutoff_q, cutoff_d;
  logic                vb_q, vb_d;

  logic [COUNT_W-1:0]  mask_cur;
  logic signed [VPOS_W:0] diff;
  logic [VPOS_W-1:0]   diff_mag;
  logic [VPOS_W-1:0]   diff_shift;
  logic [VPOS_W-1:0]   step_mask;

  assign mask_cur = col_mask(cfg_q.col_log2);

  // Next origin state for a frame boundary; the divider compares against the
  // rate that was in force during the frame just ending.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    div_d    = div_q;
    ocount_d = ocount_q;
    olfsr_d  = olfsr_q;
    if (scroll_en_i) begin
      if (div_q == cfg_q.rate) begin
        div_d = '0;
        if (ocount_q == mask_cur) begin
          ocount_d = '0;
          olfsr_d  = lfsr_next(olfsr_q);
        end else begin
          ocount_d = ocount_q + 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    // A narrower column width arriving with this frame trims the origin counter.
    ocount_d = ocount_d & col_mask(cfg_i.col_log2);
  end

  // Per-line cutoff and vertical border from the signed distance below the horizon.
  always_comb begin
    diff       = $signed({1'b0, vcount_i}) - $signed({1'b0, cfg_q.horizon});
    diff_mag   = diff[VPOS_W-1:0];
    diff_shift = diff_mag >> cfg_q.step_log2;
    step_mask  = (VPOS_W'(1) << cfg_q.step_log2) - VPOS_W'(1);
    cutoff_d   = '0;
    vb_d       = 1'b0;
    if (!diff[VPOS_W]) begin
      cutoff_d = (diff_shift > CUT_MAX) ? '1 : diff_shift[CUTOFF_W-1:0];
      vb_d     = ((diff_mag & step_mask) == '0);
    end
  end

  // Frame-rate state: config shadow, scroll divider and scroll origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      div_q    <= '0;
      olfsr_q  <= LFSR_SEED;
      ocount_q <= '0;
    end else if (frame_start_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      cfg_q    <= cfg_i;
      div_q    <= div_d;
      olfsr_q  <= olfsr_d;
      ocount_q <= ocount_d;
    end
  end

  // Pixel-rate state: working LFSR/counter reloaded each line, stepped across visible pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= LFSR_SEED;
      count_q  <= '0;
      cutoff_q <= '0;
      vb_q     <= 1'b0;
    end else if (line_start_i) begin
      lfsr_q   <= olfsr_q;
      count_q  <= ocount_q;
      cutoff_q <= cutoff_d;
      vb_q     <= vb_d;
    end else if (visible_i) begin
      count_q <= (count_q + 1'b1) & mask_cur;
      if (count_q == mask_cur) begin
        lfsr_q <= lfsr_next(lfsr_q);
      end
    end
  end

  assign solid_o  = CUTOFF_W'(lfsr_q[HEIGHT_W-1:0]) < cutoff_q;
  assign border_o = cfg_q.border_en & (vb_q | (count_q == '0));
  assign fill_o   = cfg_q.fill_color;
  assign edge_o   = cfg_q.edge_color;

endmodule

// File: rtl/parallax_scroller_engine.sv
// N-layer parallax skyline generator: per-layer skyline state, front-to-back
// priority mux over the layers and a registered RGB output.
module parallax_scroller_engine
  import parallax_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int HEIGHT_W   = 4,
  parameter int CUTOFF_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [VPOS_W-1:0]            vcount,
  input  logic                         visible,
  input  logic                         line_start,
  input  logic                         frame_start,
  input  logic                         scroll_en,
  input  logic [COL_W*NUM_LAYERS-1:0]  cfg_col_log2,
  input  logic [RATE_W*NUM_LAYERS-1:0] cfg_rate,
  input  logic [VPOS_W*NUM_LAYERS-1:0] cfg_horizon,
  input  logic [STEP_W*NUM_LAYERS-1:0] cfg_step_log2,
  input  logic [NUM_LAYERS-1:0]        cfg_border,
  input  logic [COLOR_W*NUM_LAYERS-1:0] cfg_fill,
  input  logic [COLOR_W*NUM_LAYERS-1:0] cfg_edge,
  input  logic [COLOR_W-1:0]           cfg_sky,
  output logic [COLOR_W-1:0]           rgb_out,
  output logic                         rgb_valid
);

  logic [NUM_LAYERS-1:0] solid;
  logic [NUM_LAYERS-1:0] border;
  logic [COLOR_W-1:0]    fill       [NUM_LAYERS];
  logic [COLOR_W-1:0]    edge_color [NUM_LAYERS];

  logic                  armed_q;
  logic [COLOR_W-1:0]    sky_q;
  logic [COLOR_W-1:0]    rgb_q, pix_d;
  logic                  rgb_valid_q;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    layer_cfg_t cfg;
    assign cfg.col_log2   = cfg_col_log2[field_lo(g, COL_W) +: COL_W];
    assign cfg.rate       = cfg_rate[field_lo(g, RATE_W) +: RATE_W];
    assign cfg.horizon    = cfg_horizon[field_lo(g, VPOS_W) +: VPOS_W];
    assign cfg.step_log2  = cfg_step_log2[field_lo(g, STEP_W) +: STEP_W];
    assign cfg.border_en  = cfg_border[g];
    assign cfg.fill_color = cfg_fill[field_lo(g, COLOR_W) +: COLOR_W];
    assign cfg.edge_color = cfg_edge[field_lo(g, COLOR_W) +: COLOR_W];

    parallax_layer #(
      .HEIGHT_W (HEIGHT_W),
      .CUTOFF_W (CUTOFF_W)
    ) u_layer (
      .clk           (clk),
      .rst_n         (rst_n),
      .line_start_i  (line_start),
      .frame_start_i (frame_start),
      .visible_i     (visible),
      .scroll_en_i   (scroll_en),
      .vcount_i      (vcount),
      .cfg_i         (cfg),
      .solid_o       (solid[g]),
      .border_o      (border[g]),
      .fill_o        (fill[g]),
      .edge_o        (edge_color[g])
    );
  end

  // Front-to-back priority: walking from the back layer forward lets layer 0 win last.
  always_comb begin
    pix_d = sky_q;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (solid[i]) begin
        pix_d = border[i] ? edge_color[i] : fill[i];
      end
    end
  end

  // Arm on the first frame, shadow the sky colour per frame, register the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      sky_q       <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      if (frame_start) begin
        armed_q <= 1'b1;
        sky_q   <= cfg_sky;
      end
      if (visible && armed_q) begin
        rgb_q       <= pix_d;
        rgb_valid_q <= 1'b1;
      end else begin
        rgb_q       <= '0;
        rgb_valid_q <= 1'b0;
      end
    end
  end

  assign rgb_out   = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_parallax_scroller_engine.sv
// Directed bench for parallax_scroller_engine: two layers, short 64-pixel lines,
// frames reduced to their frame_start line. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the capturing rising edge.
module tb_parallax_scroller_engine;

  localparam int NL  = 2;
  localparam int NPX = 64;

  localparam logic [8:0] SKY    = 9'h049;
  localparam logic [8:0] FILL0  = 9'h1C0;
  localparam logic [8:0] FILL0B = 9'h0F0;
  localparam logic [8:0] EDGE0  = 9'h038;
  localparam logic [8:0] FILL1  = 9'h007;
  localparam logic [8:0] EDGE1  = 9'h155;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [9:0] vcount;
  logic       visible, line_start, frame_start, scroll_en;
  logic [1:0] t_col  [NL];
  logic [2:0] t_rate [NL];
  logic [9:0] t_hor  [NL];
  logic [2:0] t_step [NL];
  logic       t_bord [NL];
  logic [8:0] t_fill [NL];
  logic [8:0] t_edge [NL];
  logic [8:0] t_sky;

  logic [2*NL-1:0]  cfg_col_log2;
  logic [3*NL-1:0]  cfg_rate;
  logic [10*NL-1:0] cfg_horizon;
  logic [3*NL-1:0]  cfg_step_log2;
  logic [NL-1:0]    cfg_border;
  logic [9*NL-1:0]  cfg_fill;
  logic [9*NL-1:0]  cfg_edge;
  logic [8:0]       rgb_out;
  logic             rgb_valid;

  assign cfg_col_log2  = {t_col[1],  t_col[0]};
  assign cfg_rate      = {t_rate[1], t_rate[0]};
  assign cfg_horizon   = {t_hor[1],  t_hor[0]};
  assign cfg_step_log2 = {t_step[1], t_step[0]};
  assign cfg_border    = {t_bord[1], t_bord[0]};
  assign cfg_fill      = {t_fill[1], t_fill[0]};
  assign cfg_edge      = {t_edge[1], t_edge[0]};

  parallax_scroller_engine #(.NUM_LAYERS(NL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vcount        (vcount),
    .visible       (visible),
    .line_start    (line_start),
    .frame_start   (frame_start),
    .scroll_en     (scroll_en),
    .cfg_col_log2  (cfg_col_log2),
    .cfg_rate      (cfg_rate),
    .cfg_horizon   (cfg_horizon),
    .cfg_step_log2 (cfg_step_log2),
    .cfg_border    (cfg_border),
    .cfg_fill      (cfg_fill),
    .cfg_edge      (cfg_edge),
    .cfg_sky       (t_sky),
    .rgb_out       (rgb_out),
    .rgb_valid     (rgb_valid)
  );

  int total = 0;
  int bad   = 0;

  logic [9:0] obs [NPX];

  // Reference state: what the bench believes the frame shadows hold, and the
  // total scroll offset (pixels) of layer 0. Layer 1 is only ever configured
  // either never solid (cutoff 0) or always solid (cutoff above every height).
  int m_col, m_rate, m_hor0, m_step0, m_hor1, m_step1, m_div, m_off;
  bit m_bord0;
  logic [8:0] m_fill0, m_edge0, m_fill1, m_sky;

  task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [8:0] lfsr_adv(input logic [8:0] s, input int n);
    logic [8:0] r = s;
    for (int k = 0; k < n; k++) r = {r[7:0], r[8] ^ r[4]};
    return r;
  endfunction

  function automatic int cutoff_of(input int vc, input int hor, input int step);
    int d = vc - hor;
    if (d < 0) return 0;
    d = d >> step;
    return (d > 31) ? 31 : d;
  endfunction

  function automatic bit vb_of(input int vc, input int hor, input int step);
    int d = vc - hor;
    return (d >= 0) && ((d % (1 << step)) == 0);
  endfunction

  // Pixel p of line vc: layer 0 column = (offset + p) / 2^col steps from the seed.
  function automatic logic [8:0] exp_pix(input int vc, input int p);
    int pos = m_off + p;
    logic [8:0] lf = lfsr_adv(9'h1FF, pos >> m_col);
    int cnt = pos % (1 << m_col);
    bit solid0 = int'(lf[3:0]) < cutoff_of(vc, m_hor0, m_step0);
    bit bord0 = m_bord0 && (vb_of(vc, m_hor0, m_step0) || cnt == 0);
    bit solid1 = cutoff_of(vc, m_hor1, m_step1) > 15;
    if (solid0) return bord0 ? m_edge0 : m_fill0;
    if (solid1) return m_fill1;
    return m_sky;
  endfunction

  task automatic run_frame(input logic scroll);
    @(negedge clk);
    vcount = 10'd482; line_start = 1'b1; frame_start = 1'b1; scroll_en = scroll;
    @(negedge clk);
    line_start = 1'b0; frame_start = 1'b0; scroll_en = 1'b0;
    if (scroll) begin
      if (m_div == m_rate) begin m_div = 0; m_off++; end
      else m_div = (m_div + 1) % 8;
    end
    m_col = t_col[0]; m_rate = t_rate[0]; m_hor0 = t_hor[0]; m_step0 = t_step[0];
    m_bord0 = t_bord[0]; m_fill0 = t_fill[0]; m_edge0 = t_edge[0];
    m_hor1 = t_hor[1]; m_step1 = t_step[1]; m_fill1 = t_fill[1]; m_sky = t_sky;
  endtask

  task automatic run_line(input string tag, input int vc);
    @(negedge clk);
    vcount = vc[9:0]; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0; visible = 1'b1;
    for (int p = 0; p < NPX; p++) begin
      @(negedge clk);
      if (p == NPX - 1) visible = 1'b0;
      obs[p] = {rgb_valid, rgb_out};
      check($sformatf("%s_px%0d", tag, p), {22'd0, rgb_valid, rgb_out}, {22'd0, 1'b1, exp_pix(vc, p)});
    end
    @(negedge clk);
    check({tag, "_blank"}, {22'd0, rgb_valid, rgb_out}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; vcount = '0; visible = 1'b0; line_start = 1'b0;
    frame_start = 1'b0; scroll_en = 1'b0;
    t_col[0] = 2'd3; t_rate[0] = 3'd1; t_hor[0] = 10'd112; t_step[0] = 3'd2;
    t_bord[0] = 1'b0; t_fill[0] = FILL0; t_edge[0] = EDGE0;
    t_col[1] = 2'd0; t_rate[1] = 3'd0; t_hor[1] = 10'd1023; t_step[1] = 3'd0;
    t_bord[1] = 1'b0; t_fill[1] = EDGE1; t_edge[1] = EDGE1;
    t_sky = SKY;
    m_col = 0; m_rate = 0; m_hor0 = 0; m_step0 = 0; m_hor1 = 0; m_step1 = 0;
    m_div = 0; m_off = 0; m_bord0 = 0; m_fill0 = '0; m_edge0 = '0; m_fill1 = '0; m_sky = '0;

    // Reset held while strobes toggle: outputs stay quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      line_start = ~line_start; frame_start = ~frame_start; visible = 1'b1;
      @(negedge clk);
      check($sformatf("rst_held_%0d", i), {22'd0, rgb_valid, rgb_out}, 32'd0);
    end
    line_start = 1'b0; frame_start = 1'b0; visible = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Out of reset but not yet armed: visible pixels produce nothing.
    @(negedge clk); visible = 1'b1;
    @(negedge clk); check("unarmed_valid", {31'd0, rgb_valid}, 32'd0);
    @(negedge clk); check("unarmed_rgb", {23'd0, rgb_out}, 32'd0);
    visible = 1'b0;

    // Layer 0 alone, scroll frozen.
    run_frame(1'b0);
    run_line("hor112", 112);
    check("hor112_first_valid", {31'd0, obs[0][9]}, 32'd1);
    check("hor112_sky0", {22'd0, obs[0]}, {22'd0, 1'b1, SKY});
    check("hor112_sky63", {22'd0, obs[63]}, {22'd0, 1'b1, SKY});
    run_line("hor111", 111);
    check("hor111_sky", {22'd0, obs[40]}, {22'd0, 1'b1, SKY});
    run_line("l128", 128);
    check("l128_p31", {22'd0, obs[31]}, {22'd0, 1'b1, SKY});
    check("l128_p32", {22'd0, obs[32]}, {22'd0, 1'b1, FILL0});
    check("l128_p63", {22'd0, obs[63]}, {22'd0, 1'b1, FILL0});

    // rate=1 over 16 frames: 8 px, one column, one LFSR step.
    for (int f = 0; f < 16; f++) run_frame(1'b1);
    run_line("scr8", 128);
    check("scr8_p23", {22'd0, obs[23]}, {22'd0, 1'b1, SKY});
    check("scr8_p24", {22'd0, obs[24]}, {22'd0, 1'b1, FILL0});
    check("scr8_p55", {22'd0, obs[55]}, {22'd0, 1'b1, FILL0});
    check("scr8_p56", {22'd0, obs[56]}, {22'd0, 1'b1, SKY});

    // Fill changed mid-frame: old colour until the next frame_start.
    t_fill[0] = FILL0B;
    run_line("tear", 128);
    check("tear_old_fill", {22'd0, obs[24]}, {22'd0, 1'b1, FILL0});
    run_frame(1'b0);
    run_line("newfill", 128);
    check("newfill", {22'd0, obs[24]}, {22'd0, 1'b1, FILL0B});

    // rate=0 over 16 frames: 16 more px, two more LFSR steps.
    t_rate[0] = 3'd0;
    run_frame(1'b0);
    for (int f = 0; f < 16; f++) run_frame(1'b1);
    run_line("scr24", 128);
    check("scr24_p7", {22'd0, obs[7]}, {22'd0, 1'b1, SKY});
    check("scr24_p8", {22'd0, obs[8]}, {22'd0, 1'b1, FILL0B});
    check("scr24_p39", {22'd0, obs[39]}, {22'd0, 1'b1, FILL0B});
    check("scr24_p40", {22'd0, obs[40]}, {22'd0, 1'b1, SKY});

    // Two layers: layer 1 saturates to always-solid, layer 0 gets borders.
    t_hor[1] = 10'd0; t_fill[1] = FILL1; t_bord[0] = 1'b1;
    run_frame(1'b0);
    run_line("two129", 129);
    check("two_l1_only", {22'd0, obs[0]}, {22'd0, 1'b1, FILL1});
    check("two_edge", {22'd0, obs[8]}, {22'd0, 1'b1, EDGE0});
    check("two_both_fill0", {22'd0, obs[9]}, {22'd0, 1'b1, FILL0B});
    check("two_l1_p40", {22'd0, obs[40]}, {22'd0, 1'b1, FILL1});
    run_line("two128", 128);
    check("vb_edge", {22'd0, obs[9]}, {22'd0, 1'b1, EDGE0});
    check("vb_l1_only", {22'd0, obs[0]}, {22'd0, 1'b1, FILL1});

    // Asynchronous reset in the middle of visible pixels.
    @(negedge clk); vcount = 10'd129; line_start = 1'b1;
    @(negedge clk); line_start = 1'b0; visible = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_valid", {31'd0, rgb_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {22'd0, rgb_valid, rgb_out}, 32'd0);
    @(negedge clk);
    visible = 1'b0;
    check("async_rst_hold", {22'd0, rgb_valid, rgb_out}, 32'd0);
    rst_n = 1'b1;
    m_div = 0; m_off = 0; m_rate = 0;
    run_frame(1'b0);
    run_frame(1'b0);
    run_line("recover", 129);
    check("rec_l1", {22'd0, obs[0]}, {22'd0, 1'b1, FILL1});
    check("rec_edge", {22'd0, obs[32]}, {22'd0, 1'b1, EDGE0});
    check("rec_fill", {22'd0, obs[33]}, {22'd0, 1'b1, FILL0B});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
